// File: rtl/wrr_pop_scheduler_pkg.sv
// Shared types and defaults for the weighted round-robin pop scheduler.
package sched_pkg;

    typedef enum logic {SELECT = 1'b0, SERVE = 1'b1} state_e;

    localparam int DEF_WWID      = 4;
    localparam int DEF_AGE_LIMIT = 16;

    // A zero weight still earns one pop so a selected requester always makes progress.
    function automatic int unsigned norm_weight(input int unsigned w);
        return (w == 0) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/wrr_pop_scheduler_if.sv
// FIFO-bank side of the scheduler: empty/weights/back-pressure in, one-hot pop out.
interface wrr_pop_scheduler_if
    import sched_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int WWID     = DEF_WWID
);
    localparam int IW = $clog2(NUM_REQS);

    logic                     blk;
    logic [NUM_REQS-1:0]      empty;
    logic [NUM_REQS*WWID-1:0] weights;
    logic [NUM_REQS-1:0]      gnt;
    logic                     gnt_vld;
    logic [IW-1:0]            cur_idx;

    modport master (input blk, empty, weights, output gnt, gnt_vld, cur_idx);
    modport slave  (output blk, empty, weights, input gnt, gnt_vld, cur_idx);
endinterface

// File: rtl/wrr_pop_scheduler_rr_first_set.sv
// Rotating find-first-set: first set bit of req at or after ptr, wrapping modulo N.
module rr_first_set #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          found
);
    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                idx   = IW'((int'(ptr) + k) % N);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/wrr_pop_scheduler.sv
// Weighted round-robin pop scheduler over NUM_REQS FIFOs, up to weight pops per turn.
// Optional starvation aging is compiled in with WRR_AGING_EN.
module wrr_pop_scheduler
    import sched_pkg::*;
#(
    parameter int NUM_REQS  = 4,
    parameter int WWID      = DEF_WWID,
    parameter int AGE_LIMIT = DEF_AGE_LIMIT
) (
    input logic                 clk,
    input logic                 rst,
    wrr_pop_scheduler_if.master bus
);
    localparam int            IW   = $clog2(NUM_REQS);
    localparam logic [IW-1:0] LAST = IW'(NUM_REQS - 1);

    state_e              state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d, cur_q, cur_d;
    logic [WWID-1:0]     credit_q, credit_d;
    logic [NUM_REQS-1:0] req, gnt;
    logic [IW-1:0]       rr_idx, sel_idx, nxt_idx;
    logic                rr_found;
    logic [WWID-1:0]     sel_w;

    assign req = ~bus.empty;

    rr_first_set #(.N(NUM_REQS)) u_rr (
        .req(req), .ptr(ptr_q), .idx(rr_idx), .found(rr_found)
    );

`ifdef WRR_AGING_EN
    localparam int            AW      = $clog2(AGE_LIMIT + 1);
    localparam logic [AW-1:0] AGE_MAX = AW'(AGE_LIMIT);

    logic [NUM_REQS-1:0][AW-1:0] age_q, age_d;
    logic [NUM_REQS-1:0]         aged;
    logic [IW-1:0]               aged_idx;
    logic                        aged_found;

    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            aged[i] = req[i] && (age_q[i] >= AGE_MAX);
            if (bus.empty[i] || gnt[i])  age_d[i] = '0;
            else if (age_q[i] != AGE_MAX) age_d[i] = age_q[i] + 1'b1;
            else                          age_d[i] = age_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) age_q <= '0;
        else      age_q <= age_d;
    end

    // Aged requesters bypass rotation; lowest index wins among them.
    rr_first_set #(.N(NUM_REQS)) u_aged (
        .req(aged), .ptr('0), .idx(aged_idx), .found(aged_found)
    );

    assign sel_idx = aged_found ? aged_idx : rr_idx;
`else
    localparam int unused_age_limit = AGE_LIMIT;
    assign sel_idx = rr_idx;
`endif

    assign sel_w   = WWID'(norm_weight(32'(bus.weights[int'(sel_idx)*WWID +: WWID])));
    assign nxt_idx = (cur_q == LAST) ? '0 : cur_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cur_d    = cur_q;
        credit_d = credit_q;
        gnt      = '0;
        case (state_q)
            SELECT: begin
                if (rr_found && !bus.blk) begin
                    cur_d    = sel_idx;
                    credit_d = sel_w;
                    state_d  = SERVE;
                end
            end
            SERVE: begin
                if (!bus.blk) begin
                    if (bus.empty[cur_q]) begin
                        state_d = SELECT;
                        ptr_d   = nxt_idx;
                    end else begin
                        gnt[cur_q] = 1'b1;
                        credit_d   = credit_q - 1'b1;
                        if (credit_q == WWID'(1)) begin
                            state_d = SELECT;
                            ptr_d   = nxt_idx;
                        end
                    end
                end
            end
            default: state_d = SELECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= SELECT;
            ptr_q    <= '0;
            cur_q    <= '0;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cur_q    <= cur_d;
            credit_q <= credit_d;
        end
    end

    assign bus.gnt     = gnt;
    assign bus.gnt_vld = |gnt;
    assign bus.cur_idx = cur_q;
endmodule

// File: tb/tb_wrr_pop_scheduler.sv
// Randomized and directed checks of wrr_pop_scheduler against a behavioural queue model.
module tb_wrr_pop_scheduler;
    localparam int N  = 4;
    localparam int W  = 4;
    localparam int AL = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wrr_pop_scheduler_if #(.NUM_REQS(N), .WWID(W)) bus ();
    wrr_pop_scheduler #(.NUM_REQS(N), .WWID(W), .AGE_LIMIT(AL)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    int cnt [N];
    int wt  [N];
    logic blk_v;

    bit m_serving;
    int m_cur, m_left, m_ptr;
    int m_age [N];
    int last_gnt;
    int cyc;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_serving = 1'b0;
        m_cur = 0; m_left = 0; m_ptr = 0;
        foreach (m_age[i]) m_age[i] = 0;
    endtask

    function automatic int pick();
        int p;
        p = -1;
`ifdef WRR_AGING_EN
        for (int i = N - 1; i >= 0; i--) if (cnt[i] > 0 && m_age[i] >= AL) p = i;
        if (p >= 0) return p;
`endif
        for (int k = 0; k < N; k++) if (cnt[(m_ptr + k) % N] > 0) return (m_ptr + k) % N;
        return p;
    endfunction

    // One clock: drive inputs after negedge, compare, advance model across the posedge.
    task automatic step();
        int eg, p;
        bit e [N];
        bus.blk = blk_v;
        for (int i = 0; i < N; i++) begin
            e[i] = (cnt[i] == 0);
            bus.empty[i] = e[i];
            bus.weights[i*W +: W] = W'(wt[i]);
        end
        #1;
        eg = -1;
        if (m_serving && !blk_v && cnt[m_cur] > 0) eg = m_cur;
        check("gnt", int'(bus.gnt), (eg < 0) ? 0 : (1 << eg));
        check("gnt_vld", int'(bus.gnt_vld), (eg >= 0) ? 1 : 0);
        check("cur_idx", int'(bus.cur_idx), m_cur);
        if (!m_serving) begin
            if (!blk_v) begin
                p = pick();
                if (p >= 0) begin
                    m_serving = 1'b1;
                    m_cur     = p;
                    m_left    = (wt[p] == 0) ? 1 : wt[p];
                end
            end
        end else if (!blk_v) begin
            if (eg < 0) begin
                m_serving = 1'b0;
                m_ptr = (m_cur + 1) % N;
            end else begin
                m_left--;
                cnt[m_cur]--;
                if (m_left == 0) begin
                    m_serving = 1'b0;
                    m_ptr = (m_cur + 1) % N;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (e[i] || eg == i) m_age[i] = 0;
            else if (m_age[i] < AL) m_age[i]++;
        end
        last_gnt = eg;
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_gnt", int'(bus.gnt), 0);
        check("rst_gnt_vld", int'(bus.gnt_vld), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_cur_idx", int'(bus.cur_idx), 0);
        rst = 1'b1;
    endtask

    initial begin
        int exp_seq [16];
        int gc [$];
        int g, base, found;
        bit inj;
        exp_seq = '{-1, 0, -1, 1, 1, -1, 2, 2, 2, -1, 3, 3, 3, 3, -1, 0};
        blk_v = 1'b0;
        cyc = 0;
        last_gnt = -1;
        foreach (cnt[i]) begin cnt[i] = 0; wt[i] = 1; end
        bus.blk = 1'b0;
        bus.empty = '1;
        bus.weights = '0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Idle: nothing to pop.
        for (int c = 0; c < 10; c++) step();
        check("idle_cur_idx", int'(bus.cur_idx), 0);

        // Weights 1..4, all FIFOs deep: literal grant/bubble pattern.
        wt = '{1, 2, 3, 4};
        foreach (cnt[i]) cnt[i] = 8;
        for (int c = 0; c < 16; c++) begin
            step();
            check("wrr_seq", last_gnt, exp_seq[c]);
        end
        step();
        step();
        check("pre_rst_gnt", last_gnt, 1);
        do_reset();

        // Weight 0 acts as 1: alternate select/grant.
        foreach (cnt[i]) cnt[i] = 0;
        wt[2] = 0;
        cnt[2] = 3;
        base = cyc;
        for (int c = 0; c < 8; c++) begin
            step();
            if (last_gnt == 2) gc.push_back(cyc - 1 - base);
        end
        check("w0_count", gc.size(), 3);
        if (gc.size() == 3) begin
            check("w0_cyc0", gc[0], 1);
            check("w0_cyc1", gc[1], 3);
            check("w0_cyc2", gc[2], 5);
        end
        do_reset();

        // Back-pressure mid-service holds remaining credit.
        foreach (cnt[i]) cnt[i] = 0;
        wt[1] = 4;
        cnt[1] = 8;
        step();
        step();
        check("blk_first", last_gnt, 1);
        blk_v = 1'b1;
        g = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (last_gnt >= 0) g++;
        end
        check("blk_hold", g, 0);
        blk_v = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check("blk_resume", last_gnt, 1);
        end
        step();
        check("blk_bubble", last_gnt, -1);
        do_reset();

        // Early end on empty, then the waiting requester (aging) or next in rotation.
        foreach (cnt[i]) cnt[i] = 0;
        wt = '{4, 2, 2, 2};
        cnt[0] = 2;
        cnt[3] = 2;
        inj = 1'b0;
        g = 0;
        found = -1;
        for (int c = 0; c < 30 && found < 0; c++) begin
            if (cnt[0] == 0 && !inj) begin
                cnt[1] = 3;
                inj = 1'b1;
            end
            step();
            if (last_gnt == 0) g++;
            if (last_gnt > 0) found = last_gnt;
        end
        check("early_end_pops", g, 2);
`ifdef WRR_AGING_EN
        check("next_after_empty", found, 3);
`else
        check("next_after_empty", found, 1);
`endif
        do_reset();

        // Randomized traffic, back-pressure, weight changes and occasional reset.
        foreach (cnt[i]) cnt[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            int r;
            blk_v = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) begin
                r = $urandom_range(0, N - 1);
                if (cnt[r] < 20) cnt[r] += $urandom_range(1, 4);
            end
            if ($urandom_range(0, 30) == 0) wt[$urandom_range(0, N - 1)] = $urandom_range(0, 15);
            if ($urandom_range(0, 700) == 0) do_reset();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
